// File: rtl/ps2_command_sequencer_if.sv
// rtl/ps2_command_sequencer_if.sv - keyboard/processor/LCD signal bundle for ps2_command_sequencer
//
// Signals:
//   key_pressed, key_data, key_ascii : scan-code event from the PS2 front end
//   cmd_word, cmd_len, cmd_valid     : command offered to the processor
//   cmd_ready                        : processor accepts the command
//   lcd_write_en, lcd_write_data     : one-cycle LCD write strobe and byte
//   overflow                         : sticky dropped-character flag
// Modports: slave is the sequencer side, master is the environment side.
interface ps2_command_sequencer_if #(
    parameter int MAX_CHARS = 4
);
    logic                   key_pressed;
    logic [7:0]             key_data;
    logic [7:0]             key_ascii;
    logic [8*MAX_CHARS-1:0] cmd_word;
    logic [2:0]             cmd_len;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   lcd_write_en;
    logic [7:0]             lcd_write_data;
    logic                   overflow;

    modport slave (
        input  key_pressed, key_data, key_ascii, cmd_ready,
        output cmd_word, cmd_len, cmd_valid, lcd_write_en, lcd_write_data, overflow
    );

    modport master (
        output key_pressed, key_data, key_ascii, cmd_ready,
        input  cmd_word, cmd_len, cmd_valid, lcd_write_en, lcd_write_data, overflow
    );
endinterface

// File: rtl/ps2_command_sequencer.sv
// rtl/ps2_command_sequencer.sv - PS2 scan-code decoder assembling a command word for the processor
//
// Ports:
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   bus    : ps2_command_sequencer_if.slave (key event in, command/LCD/overflow out)
// Plain make codes build a right-packed command word (newest byte in [7:0]),
// each edit is echoed to the LCD, and Enter offers the word via valid/ready.
module ps2_command_sequencer #(
    parameter int MAX_CHARS = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    ps2_command_sequencer_if.slave  bus
);
    localparam int         W       = 8 * MAX_CHARS;
    localparam logic [2:0] MAX_CNT = 3'(MAX_CHARS);

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic {COLLECT, ISSUE} state_t;

    state_t       state_q;
    logic [W-1:0] buf_q;
    logic [2:0]   count_q;
    logic         ext_pend_q;
    logic         brk_pend_q;
    logic [2:0]   cmd_len_q;
    logic         cmd_valid_q;
    logic         lcd_en_q;
    logic [7:0]   lcd_data_q;
    logic         overflow_q;

    logic       is_prefix;
    logic       plain_make;
    logic [7:0] char_d;

    assign is_prefix  = (bus.key_data == SC_EXT) || (bus.key_data == SC_BRK);
    // A make code only counts when no prefix is pending; the byte that
    // follows E0 and/or F0 is consumed by the prefix tracker.
    assign plain_make = bus.key_pressed && !ext_pend_q && !brk_pend_q && !is_prefix;
    // Space has no entry in the ASCII mapper, so it is substituted here.
    assign char_d     = (bus.key_data == SC_SPACE) ? 8'h20 : bus.key_ascii;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= COLLECT;
            buf_q       <= '0;
            count_q     <= '0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            cmd_len_q   <= '0;
            cmd_valid_q <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            lcd_en_q <= 1'b0;

            // Prefix tracking runs in every state so release codes seen
            // during ISSUE cannot leak through as make codes later.
            if (bus.key_pressed) begin
                if (bus.key_data == SC_EXT) begin
                    ext_pend_q <= 1'b1;
                end else if (bus.key_data == SC_BRK) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    ext_pend_q <= 1'b0;
                    brk_pend_q <= 1'b0;
                end
            end

            case (state_q)
                COLLECT: begin
                    if (plain_make) begin
                        if (bus.key_data == SC_ENTER) begin
                            if (count_q != 3'd0) begin
                                cmd_len_q   <= count_q;
                                cmd_valid_q <= 1'b1;
                                state_q     <= ISSUE;
                            end
                        end else if (bus.key_data == SC_BKSP) begin
                            if (count_q != 3'd0) begin
                                buf_q      <= buf_q >> 8;
                                count_q    <= count_q - 3'd1;
                                lcd_en_q   <= 1'b1;
                                lcd_data_q <= 8'h08;
                            end
                        end else if (char_d != 8'h00) begin
                            if (count_q < MAX_CNT) begin
                                buf_q      <= (buf_q << 8) | W'(char_d);
                                count_q    <= count_q + 3'd1;
                                lcd_en_q   <= 1'b1;
                                lcd_data_q <= char_d;
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    // Make codes are dropped here, including one that
                    // coincides with the transfer.
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        buf_q       <= '0;
                        count_q     <= '0;
                        cmd_len_q   <= '0;
                        overflow_q  <= 1'b0;
                        state_q     <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign bus.cmd_word       = buf_q;
    assign bus.cmd_len        = cmd_len_q;
    assign bus.cmd_valid      = cmd_valid_q;
    assign bus.lcd_write_en   = lcd_en_q;
    assign bus.lcd_write_data = lcd_data_q;
    assign bus.overflow       = overflow_q;
endmodule

// File: doc/ps2_command_sequencer.md
Name: ps2_command_sequencer

Overview:
- Sits between the PS2 keyboard interface and the processor.
- Decodes the raw scan-code stream, handling make, break and extended prefixes.
- Assembles up to MAX_CHARS ASCII characters into a right-packed command word. The newest character is always in bits [7:0].
- Echoes each edit to the LCD as a one-cycle write. On Enter, offers the word to the processor through a valid/ready handshake.

Parameters:
- MAX_CHARS, 4, maximum buffered characters. Command word width is 8*MAX_CHARS. Supported range is 1..4.

Ports:
- clock  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- key_pressed  in  1  one-cycle strobe; key_data is valid this cycle
- key_data  in  8  raw PS2 scan-code byte
- key_ascii  in  8  ASCII of key_data from the existing mapper; 0x00 means unmapped
- cmd_word  out  8*MAX_CHARS  packed command; unused upper bytes are 0
- cmd_len  out  3  number of characters in cmd_word
- cmd_valid  out  1  command offered to the processor
- cmd_ready  in  1  processor accepts the command
- lcd_write_en  out  1  one-cycle LCD write strobe
- lcd_write_data  out  8  byte to write to the LCD
- overflow  out  1  sticky; a character was dropped because the buffer was full

Behaviour:
- Reset (async, resetn=0): all outputs 0, buffer 0, count 0, both prefix flags 0, FSM in COLLECT.
- Only cycles with key_pressed=1 are key events. All outputs are registered, so there is 1-cycle latency from an event to its effect.
- Prefix tracker (active in every FSM state):
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte while brk_pend=1 or ext_pend=1 is discarded and clears both flags.
  - Sequence E0,F0,xx: the F0 sets brk_pend while ext_pend stays 1; xx is discarded and clears both.
  - A byte is a plain make code only when both flags are 0 and it is not E0 or F0.
- FSM state COLLECT, for each plain make code:
  - 0x5A (Enter), count>0: latch cmd_len=count, assert cmd_valid next cycle, go to ISSUE. No LCD write.
  - 0x5A (Enter), count=0: ignored.
  - 0x66 (Backspace), count>0: buffer shifts right 8 (zero-fill), count-1, lcd_write_en=1, lcd_write_data=0x08.
  - 0x66 (Backspace), count=0: ignored.
  - 0x29 (Space): treated as character 0x20.
  - key_ascii≠0 or Space, count<MAX_CHARS: buffer shifts left 8 with the character in [7:0], count+1, lcd_write_en=1, lcd_write_data=character.
  - Same character, count=MAX_CHARS: buffer unchanged, no LCD write, overflow set to 1.
  - Any other code: ignored.
- FSM state ISSUE:
  - cmd_valid=1; cmd_word and cmd_len held stable.
  - Plain make codes are dropped: no buffer change, no LCD write, overflow unchanged. The prefix tracker keeps running, so the F0,5A release of Enter never retriggers.
  - On cmd_valid & cmd_ready at a clock edge: next cycle cmd_valid=0, buffer=0, count=0, cmd_len=0, overflow=0, state=COLLECT.
  - A make code in the same cycle as the transfer is dropped.
- cmd_word tracks the live buffer in COLLECT. cmd_len reads 0 outside ISSUE.
- cmd_ready while in COLLECT is ignored.
- lcd_write_en is never high for two consecutive cycles unless key events occur on consecutive cycles.
- resetn deasserted mid-ISSUE or mid-prefix: everything is cleared immediately and the pending command is lost.
- Count arithmetic saturates; it never wraps.

Test Plan:
- Type "FD" as 2B,F0,2B,23,F0,23,then 5A, with cmd_ready=0:
  - LCD writes 0x46 then 0x44.
  - cmd_word=0x00004644, cmd_len=2, cmd_valid=1 one cycle after the 5A event.
  - Raise cmd_ready: cmd_valid=0 and cmd_word=0 next cycle.
- Type "FDX" then Backspace 66:
  - LCD gets 0x08.
  - cmd_word goes from 0x00464458 to 0x00004644.
  - Then Backspace ×3: count stays 0, only two more 0x08 writes.
- Type 5 characters 1C,32,21,23,24 (A–E), MAX_CHARS=4:
  - cmd_word=0x41424344.
  - Fifth character produces no LCD write; overflow=1.
  - Enter plus handshake clears overflow.
- Enter with empty buffer: 5A,F0,5A at count=0 -> cmd_valid stays 0, no LCD write.
- In ISSUE with cmd_ready=0, feed F0,5A,1C,E0,F0,75:
  - cmd_word unchanged, no LCD writes.
  - After the handshake, cmd_valid does not reassert.
- Reset mid-ISSUE, and reset between E0 and the following byte:
  - All outputs 0.
  - The next byte, 1C, is accepted as 'A' (0x41).
